// File: rtl/screen_sequencer_pkg.sv
// Shared definitions for the screen-flow controller: state encodings and frame/hold constants.
package screen_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_TITLE_DRAW = 3'd1,
    S_TITLE_WAIT = 3'd2,
    S_GAME_START = 3'd3,
    S_GAME       = 3'd4,
    S_END_DRAW   = 3'd5,
    S_END_HOLD   = 3'd6,
    S_END_WAIT   = 3'd7
  } state_t;

  localparam int FRAME_PIXELS        = 76800;
  localparam int HOLD_CYCLES_DEFAULT = 50000000;

endpackage

// File: rtl/screen_sequencer_key_edge_sync.sv
// Two-flop synchronizer for an asynchronous key, followed by a registered rising-edge pulse.
module key_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic pulse
);

  logic meta;
  logic sync;
  logic sync_d;

  // The pulse is registered so it appears exactly 3 clocks after the key edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
      pulse  <= 1'b0;
    end else begin
      meta   <= key;
      sync   <= meta;
      sync_d <= sync;
      pulse  <= sync & ~sync_d;
    end
  end

endmodule

// File: rtl/screen_sequencer.sv
// Screen-flow controller: sequences title, game and end screens and drives screen_display
// selection/plot signals plus game-core enable/reset.
module screen_sequencer
  import screen_sequencer_pkg::*;
#(
  parameter int HOLD_CYCLES = HOLD_CYCLES_DEFAULT,
  parameter int HOLD_W      = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_key,
  input  logic       game_over,
  input  logic       game_won,
  input  logic       draw_done,
  output logic       display_title,
  output logic       display_end,
  output logic       display_win,
  output logic       plot,
  output logic       writeEn,
  output logic       game_enable,
  output logic       game_reset,
  output logic [2:0] state_dbg
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

  state_t            state;
  state_t            next_state;
  logic              win_flag;
  logic              win_next;
  logic [HOLD_W-1:0] hold_cnt;
  logic              start_pulse;

  key_edge_sync u_start_sync (
    .clk   (clk),
    .reset (reset),
    .key   (start_key),
    .pulse (start_pulse)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      win_flag <= 1'b0;
    end else begin
      state    <= next_state;
      win_flag <= win_next;
    end
  end

  // Counter only runs in the hold state, so it is already zero when the hold begins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if (state == S_END_HOLD) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end else begin
      hold_cnt <= '0;
    end
  end

  // writeEn trails plot by one clock to line up with screen_display's registered pixel outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      writeEn <= 1'b0;
    end else begin
      writeEn <= plot;
    end
  end

  always_comb begin
    next_state    = state;
    win_next      = win_flag;
    display_title = 1'b0;
    display_end   = 1'b0;
    display_win   = 1'b0;
    plot          = 1'b0;
    game_enable   = 1'b0;
    game_reset    = 1'b0;

    case (state)
      S_IDLE: begin
        next_state = S_TITLE_DRAW;
      end
      S_TITLE_DRAW: begin
        plot          = 1'b1;
        display_title = 1'b1;
        if (draw_done) next_state = S_TITLE_WAIT;
      end
      S_TITLE_WAIT: begin
        display_title = 1'b1;
        if (start_pulse) next_state = S_GAME_START;
      end
      S_GAME_START: begin
        game_reset = 1'b1;
        next_state = S_GAME;
      end
      S_GAME: begin
        game_enable = 1'b1;
        if (game_won || game_over) begin
          win_next   = game_won;
          next_state = S_END_DRAW;
        end
      end
      S_END_DRAW: begin
        plot        = 1'b1;
        display_end = 1'b1;
        display_win = win_flag;
        if (draw_done) next_state = S_END_HOLD;
      end
      S_END_HOLD: begin
        display_end = 1'b1;
        display_win = win_flag;
        if (hold_cnt == HOLD_LAST) next_state = S_END_WAIT;
      end
      S_END_WAIT: begin
        display_end = 1'b1;
        display_win = win_flag;
        if (start_pulse) begin
          win_next   = 1'b0;
          next_state = S_TITLE_DRAW;
        end
      end
      default: begin
        next_state = S_IDLE;
      end
    endcase
  end

  assign state_dbg = state;

endmodule
